// File: rtl/uart_wb_lane_bridge.sv
// Wishbone slave front-end for the UART register file: each bus access is split into one
// 8-bit register access per selected byte lane, and read bytes are gathered back into the bus word.
module uart_wb_lane_bridge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int RD_LAT = 1
) (
   input  logic                                  clock,
   input  logic                                  wb_rst_i,
   input  logic [ADDR_W-1:0]                     wb_adr_i,
   input  logic [DATA_W-1:0]                     wb_dat_i,
   input  logic [DATA_W/8-1:0]                   wb_sel_i,
   input  logic                                  wb_we_i,
   input  logic                                  wb_stb_i,
   input  logic                                  wb_cyc_i,
   output logic                                  wb_ack_o,
   output logic [DATA_W-1:0]                     wb_dat_o,
   output logic                                  busy_o,
   output logic [ADDR_W+$clog2(DATA_W/8)-1:0]    reg_addr_o,
   output logic                                  reg_we_o,
   output logic                                  reg_re_o,
   output logic [7:0]                            reg_wdat_o,
   input  logic [7:0]                            reg_rdat_i
);

   localparam int BYTES = DATA_W / 8;
   localparam int LB    = $clog2(BYTES);
   localparam int LW    = (LB > 0) ? LB : 1;
   localparam int AW    = ADDR_W + LB;

   generate
      if ((DATA_W != 8) && (DATA_W != 32)) begin : g_bad_data_w
         $error("uart_wb_lane_bridge: DATA_W must be 8 or 32");
      end
      if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_rd_lat
         $error("uart_wb_lane_bridge: RD_LAT must be in 1..4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

   state_t                  r_state;
   logic [ADDR_W-1:0]       r_adr;
   logic                    r_we;
   logic [BYTES-1:0]        r_mask;
   logic [LW-1:0]           r_lane;
   logic [BYTES-1:0][7:0]   r_dat;
   logic [BYTES-1:0][7:0]   r_buf;
   logic [1:0]              r_cnt;

   logic [BYTES-1:0][7:0]   w_din;
   logic [BYTES-1:0]        w_mask_clr;
   logic [BYTES-1:0][7:0]   w_buf_upd;
   logic [LW-1:0]           w_first_lane;
   logic [LW-1:0]           w_next_lane;
   logic                    w_done;

   function automatic logic [LW-1:0] f_lowest(input logic [BYTES-1:0] m);
      f_lowest = '0;
      for (int i = BYTES - 1; i >= 0; i--)
         if (m[i]) f_lowest = LW'(i);
   endfunction

   function automatic logic [AW-1:0] f_byte_addr(input logic [ADDR_W-1:0] adr,
                                                 input logic [LW-1:0] lane);
      f_byte_addr = (AW'(adr) << LB) | AW'(lane);
   endfunction

   assign w_din        = wb_dat_i;
   assign w_first_lane = f_lowest(wb_sel_i);
   assign w_next_lane  = f_lowest(w_mask_clr);

   // A lane completes on its write strobe, or on the last cycle of its read wait.
   always_comb begin
      w_mask_clr         = r_mask;
      w_mask_clr[r_lane] = 1'b0;
      w_buf_upd          = r_buf;
      w_buf_upd[r_lane]  = reg_rdat_i;
      w_done             = ((r_state == ACCESS) && r_we) ||
                           ((r_state == WAIT) && (r_cnt == 2'd0));
   end

   always_ff @(posedge clock) begin
      if (wb_rst_i) begin
         r_state    <= IDLE;
         wb_ack_o   <= 1'b0;
         wb_dat_o   <= '0;
         busy_o     <= 1'b0;
         reg_addr_o <= '0;
         reg_we_o   <= 1'b0;
         reg_re_o   <= 1'b0;
         reg_wdat_o <= '0;
      end else begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         reg_we_o <= 1'b0;
         reg_re_o <= 1'b0;
         case (r_state)
            IDLE: begin
               if (wb_cyc_i && wb_stb_i) begin
                  r_adr  <= wb_adr_i;
                  r_we   <= wb_we_i;
                  r_mask <= wb_sel_i;
                  r_dat  <= w_din;
                  r_buf  <= '0;
                  r_lane <= w_first_lane;
                  busy_o <= 1'b1;
                  if (wb_sel_i == '0) begin
                     r_state  <= ACK;
                     wb_ack_o <= 1'b1;
                  end else begin
                     r_state    <= ACCESS;
                     reg_addr_o <= f_byte_addr(wb_adr_i, w_first_lane);
                     reg_wdat_o <= w_din[w_first_lane];
                     reg_we_o   <= wb_we_i;
                     reg_re_o   <= !wb_we_i;
                  end
               end
            end
            ACCESS: begin
               if (!r_we) begin
                  r_state <= WAIT;
                  r_cnt   <= 2'(RD_LAT - 1);
               end
            end
            WAIT: begin
               if (r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
            end
            ACK: begin
               r_state <= IDLE;
               busy_o  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase

         // A dropped cycle wins over both ack and lane advance: the access is abandoned.
         if (w_done) begin
            r_mask <= w_mask_clr;
            if (!r_we) r_buf <= w_buf_upd;
            if (!wb_cyc_i) begin
               r_state <= IDLE;
               busy_o  <= 1'b0;
            end else if (w_mask_clr == '0) begin
               r_state  <= ACK;
               wb_ack_o <= 1'b1;
               wb_dat_o <= r_we ? '0 : w_buf_upd;
            end else begin
               r_state    <= ACCESS;
               r_lane     <= w_next_lane;
               reg_addr_o <= f_byte_addr(r_adr, w_next_lane);
               reg_wdat_o <= r_dat[w_next_lane];
               reg_we_o   <= r_we;
               reg_re_o   <= !r_we;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_wb_lane_bridge.sv
// Bench for uart_wb_lane_bridge: a 32-bit/RD_LAT=2 and an 8-bit/RD_LAT=1 instance, each
// attached to a small register-file model, checked against a transaction-level reference.
module tb_uart_wb_lane_bridge;

   localparam int A_LAT = 2;
   localparam int B_LAT = 1;

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic rst;

   logic [2:0]  a_adr;
   logic [31:0] a_dat;
   logic [3:0]  a_sel;
   logic        a_we, a_stb, a_cyc;
   logic        a_ack, a_busy, a_rwe, a_rre;
   logic [31:0] a_dato;
   logic [4:0]  a_raddr;
   logic [7:0]  a_rwdat, a_rrdat;

   logic [2:0]  b_adr;
   logic [7:0]  b_dat;
   logic [0:0]  b_sel;
   logic        b_we, b_stb, b_cyc;
   logic        b_ack, b_busy, b_rwe, b_rre;
   logic [7:0]  b_dato;
   logic [2:0]  b_raddr;
   logic [7:0]  b_rwdat, b_rrdat;

   uart_wb_lane_bridge #(.DATA_W(32), .ADDR_W(3), .RD_LAT(A_LAT)) u_a (
      .clock(clock), .wb_rst_i(rst), .wb_adr_i(a_adr), .wb_dat_i(a_dat), .wb_sel_i(a_sel),
      .wb_we_i(a_we), .wb_stb_i(a_stb), .wb_cyc_i(a_cyc), .wb_ack_o(a_ack), .wb_dat_o(a_dato),
      .busy_o(a_busy), .reg_addr_o(a_raddr), .reg_we_o(a_rwe), .reg_re_o(a_rre),
      .reg_wdat_o(a_rwdat), .reg_rdat_i(a_rrdat));

   uart_wb_lane_bridge #(.DATA_W(8), .ADDR_W(3), .RD_LAT(B_LAT)) u_b (
      .clock(clock), .wb_rst_i(rst), .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel),
      .wb_we_i(b_we), .wb_stb_i(b_stb), .wb_cyc_i(b_cyc), .wb_ack_o(b_ack), .wb_dat_o(b_dato),
      .busy_o(b_busy), .reg_addr_o(b_raddr), .reg_we_o(b_rwe), .reg_re_o(b_rre),
      .reg_wdat_o(b_rwdat), .reg_rdat_i(b_rrdat));

   // Register-file models: read data appears exactly RD_LAT cycles after the read strobe.
   logic [7:0] a_mem [32];
   logic [1:0] a_v;
   logic [7:0] a_d1, a_d2;
   always @(posedge clock) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) a_mem[i] <= 8'(8'h10 + i);
         a_v <= '0;
      end else begin
         if (a_rwe) a_mem[a_raddr] <= a_rwdat;
         a_v  <= {a_v[0], a_rre};
         a_d1 <= a_mem[a_raddr];
         a_d2 <= a_d1;
      end
   end
   assign a_rrdat = a_v[1] ? a_d2 : 8'hEE;

   logic [7:0] b_mem [8];
   logic       b_v;
   logic [7:0] b_d1;
   always @(posedge clock) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) b_mem[i] <= 8'(8'h5B + i);
         b_v <= 1'b0;
      end else begin
         if (b_rwe) b_mem[b_raddr] <= b_rwdat;
         b_v  <= b_rre;
         b_d1 <= b_mem[b_raddr];
      end
   end
   assign b_rrdat = b_v ? b_d1 : 8'hEE;

   logic [13:0] a_log [$];
   logic [11:0] b_log [$];
   int a_both, b_both, a_acks, b_acks;
   always @(negedge clock) begin
      if (a_rwe || a_rre) a_log.push_back({a_rwe, a_raddr, a_rwdat});
      if (a_rwe && a_rre) a_both++;
      if (a_ack) a_acks++;
      if (b_rwe || b_rre) b_log.push_back({b_rwe, b_raddr, b_rwdat});
      if (b_rwe && b_rre) b_both++;
      if (b_ack) b_acks++;
   end

   logic [7:0] ra_mem [32];
   logic [7:0] rb_mem [8];
   int n_cmp, n_bad;

   task automatic ref_init();
      for (int i = 0; i < 32; i++) ra_mem[i] = 8'(8'h10 + i);
      for (int i = 0; i < 8; i++) rb_mem[i] = 8'(8'h5B + i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // abort_k >= 0: drop the cycle once lane number abort_k (0-based among selected) has strobed.
   task automatic run32(input logic [2:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input int abort_k);
      logic [13:0] exp_q [$];
      logic [31:0] exp_rd;
      int n, lat, acks0, kd;
      bit seen;
      exp_rd = '0;
      n = 0;
      for (int l = 0; l < 4; l++) begin
         if (sel[l] && (abort_k < 0 || n <= abort_k)) begin
            exp_q.push_back({we, adr, 2'(l), we ? dat[8*l +: 8] : 8'h00});
            if (we) ra_mem[{adr, 2'(l)}] = dat[8*l +: 8];
            else    exp_rd[8*l +: 8] = ra_mem[{adr, 2'(l)}];
            n++;
         end
      end
      lat = (sel == 4'd0) ? 1 : $countones(sel) * (we ? 1 : 1 + A_LAT) + 1;
      a_log.delete();
      a_both = 0;
      acks0 = a_acks;
      seen = 0;
      kd = -100;
      a_adr = adr; a_we = we; a_sel = sel; a_dat = dat; a_cyc = 1'b1; a_stb = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock); #1;
         if (abort_k >= 0) begin
            if (k == kd + (we ? 1 : 1 + A_LAT)) chk("a_abort_idle", a_busy, 0);
            if (a_cyc && a_log.size() == abort_k + 1) begin
               a_cyc = 1'b0; a_stb = 1'b0; kd = k;
            end
            if (k == 14) break;
         end else if (a_ack) begin
            seen = 1;
            chk("a_latency", k, lat);
            chk("a_rdata", a_dato, exp_rd);
            a_cyc = 1'b0; a_stb = 1'b0;
            break;
         end
      end
      a_cyc = 1'b0; a_stb = 1'b0;
      if (abort_k < 0 && !seen) chk("a_ack_timeout", 0, 1);
      @(negedge clock); #1;
      chk("a_after_ack", a_ack, 0);
      chk("a_after_dat", a_dato, 0);
      chk("a_after_busy", a_busy, 0);
      chk("a_ack_count", a_acks - acks0, (abort_k < 0) ? 1 : 0);
      chk("a_nstrobe", a_log.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < a_log.size())
            chk("a_strobe", we ? a_log[i] : {a_log[i][13:8], 8'h00}, exp_q[i]);
      chk("a_we_re_excl", a_both, 0);
   endtask

   task automatic run8(input logic [2:0] adr, input logic we, input logic [0:0] sel,
                       input logic [7:0] dat);
      logic [7:0] exp_rd;
      int lat, acks0;
      bit seen;
      exp_rd = 8'h00;
      if (sel[0]) begin
         if (we) rb_mem[adr] = dat;
         else    exp_rd = rb_mem[adr];
      end
      lat = sel[0] ? (we ? 2 : 2 + B_LAT) : 1;
      b_log.delete();
      b_both = 0;
      acks0 = b_acks;
      seen = 0;
      b_adr = adr; b_we = we; b_sel = sel; b_dat = dat; b_cyc = 1'b1; b_stb = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock); #1;
         if (b_ack) begin
            seen = 1;
            chk("b_latency", k, lat);
            chk("b_rdata", b_dato, exp_rd);
            b_cyc = 1'b0; b_stb = 1'b0;
            break;
         end
      end
      b_cyc = 1'b0; b_stb = 1'b0;
      if (!seen) chk("b_ack_timeout", 0, 1);
      @(negedge clock); #1;
      chk("b_after_busy", b_busy, 0);
      chk("b_ack_count", b_acks - acks0, 1);
      chk("b_nstrobe", b_log.size(), sel[0] ? 1 : 0);
      if (sel[0] && b_log.size() > 0)
         chk("b_strobe", we ? b_log[0] : {b_log[0][11:8], 8'h00},
             {we, adr, we ? dat : 8'h00});
      chk("b_we_re_excl", b_both, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int c1, c2, acks0, snap, ab;
   logic [3:0] rs;
   logic rw;

   initial begin
      n_cmp = 0; n_bad = 0;
      a_adr = '0; a_dat = '0; a_sel = '0; a_we = 1'b0;
      b_adr = '0; b_dat = '0; b_sel = '0; b_we = 1'b0; b_stb = 1'b0; b_cyc = 1'b0;
      ref_init();
      rst = 1'b1; a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_sel = 4'hF;
      repeat (2) begin
         @(negedge clock);
         chk("rst_ack", a_ack, 0);
         chk("rst_rwe", a_rwe, 0);
         chk("rst_rre", a_rre, 0);
         chk("rst_dat", a_dato, 0);
         chk("rst_b_ack", b_ack, 0);
      end
      rst = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
      @(negedge clock); #1;
      chk("rst_busy_a", a_busy, 0);
      chk("rst_busy_b", b_busy, 0);

      run32(3'd1, 1'b1, 4'b0101, 32'hAABBCCDD, -1);
      run32(3'd0, 1'b0, 4'b1111, 32'h0, -1);
      run32(3'd2, 1'b0, 4'b0000, 32'h12345678, -1);
      run32(3'd0, 1'b1, 4'b1111, 32'h01020304, 0);
      run32(3'd0, 1'b0, 4'b0011, 32'h0, -1);
      run8(3'd5, 1'b0, 1'b1, 8'h00);

      // Strobe held across two transactions on the 8-bit instance.
      b_log.delete();
      c1 = -1; c2 = -1;
      b_adr = 3'd5; b_we = 1'b0; b_sel = 1'b1; b_cyc = 1'b1; b_stb = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clock); #1;
         if (c1 > 0 && k == c1 + 1) chk("b_bb_idle", b_busy, 0);
         if (b_ack) begin
            chk("b_bb_data", b_dato, rb_mem[5]);
            if (c1 < 0) c1 = k;
            else begin
               c2 = k; b_cyc = 1'b0; b_stb = 1'b0;
               break;
            end
         end
      end
      b_cyc = 1'b0; b_stb = 1'b0;
      chk("b_bb_first", c1, 3);
      chk("b_bb_gap", c2 - c1, 4);
      chk("b_bb_nstrobe", b_log.size(), 2);
      @(negedge clock); #1;

      // Reset in the middle of a 4-lane read.
      a_log.delete();
      acks0 = a_acks;
      a_adr = 3'd3; a_we = 1'b0; a_sel = 4'hF; a_cyc = 1'b1; a_stb = 1'b1;
      repeat (4) @(negedge clock);
      rst = 1'b1;
      @(negedge clock); #1;
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_rre", a_rre, 0);
      snap = a_log.size();
      rst = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
      repeat (8) @(negedge clock);
      #1;
      chk("mid_rst_nostrobe", a_log.size(), snap);
      chk("mid_rst_noack", a_acks - acks0, 0);
      ref_init();

      for (int t = 0; t < 24; t++) begin
         rs = 4'($urandom);
         rw = 1'($urandom);
         ab = -1;
         if ($countones(rs) >= 2 && $urandom_range(0, 3) == 0)
            ab = int'($urandom_range(0, $countones(rs) - 2));
         run32(3'($urandom), rw, rs, $urandom, ab);
      end
      for (int t = 0; t < 10; t++)
         run8(3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
